pipe_issue_unit: RTL and testbench

Program sequencer and result collector for the 4-stage 8-bit pipelined processor. It holds a small program store, streams one instruction per cycle onto the processor's `instr` input, and captures each instruction's `res` into a result buffer by tracking the fixed pipeline latency. A host reads the results back. It is the driving and collecting end of the processor's instr/res interface.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/latency_tag_pipe.sv | 43 ++++
 rtl/pipe_issue_unit.sv | 135 +++++++++++++
 tb/tb_pipe_issue_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined processor and its issue unit:
// instruction/result widths, opcode encodings and the issue-unit FSM states.
package pipe_pkg;

  localparam int INSTR_W = 8;
  localparam int RES_W   = 8;

  // Opcode field instr[7:6]
  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10
  } state_t;

endpackage

// File: rtl/latency_tag_pipe.sv
// Valid+tag delay line matching the processor latency. A tag pushed on one
// edge emerges on out_vld/out_tag LAT edges later, which is exactly when the
// processor's res for that instruction is stable and ready to be captured.
module latency_tag_pipe #(
  parameter int LAT   = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  output logic             out_vld,
  output logic [TAG_W-1:0] out_tag,
  output logic             upstream_empty
);

  logic [LAT:0]     vld_p;
  logic [TAG_W-1:0] tag_p [LAT+1];

  // Valid bits shift every edge; stage 0 takes the push strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p <= {vld_p[LAT-1:0], push};
    end
  end

  // Tags travel alongside their valid bits and need no reset
  always_ff @(posedge clk) begin
    tag_p[0] <= push_tag;
    for (int i = 1; i <= LAT; i++) begin
      tag_p[i] <= tag_p[i-1];
    end
  end

  assign out_vld        = vld_p[LAT];
  assign out_tag        = tag_p[LAT];
  // Nothing behind the output stage: the pipe is empty after the next edge
  // unless something new is pushed.
  assign upstream_empty = ~|vld_p[LAT-1:0];

endmodule

// File: rtl/pipe_issue_unit.sv
// Program sequencer and result collector for the 4-stage 8-bit pipelined
// processor. Streams a stored program onto instr, one word per cycle, and
// captures each res into the result buffer by tracking the fixed latency.
module pipe_issue_unit
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int LAT    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic [ADDR_W:0]    len,
  output logic [INSTR_W-1:0] instr,
  input  logic [RES_W-1:0]   res,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    count,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [RES_W-1:0]   rd_data
);

  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] PC_ONE  = 1;

  logic [INSTR_W-1:0] prog   [DEPTH];
  logic [RES_W-1:0]   result [DEPTH];

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W:0]    len_r;

  logic               push;
  logic               last_issue;
  logic               cap_vld;
  logic [ADDR_W-1:0]  cap_tag;
  logic               pipe_upstream_empty;

  assign push       = (state == ISSUE);
  assign last_issue = ({1'b0, pc} == (len_r - CNT_ONE));

  latency_tag_pipe #(
    .LAT   (LAT),
    .TAG_W (ADDR_W)
  ) u_tag_pipe (
    .clk            (clk),
    .rst            (rst),
    .push           (push),
    .push_tag       (pc),
    .out_vld        (cap_vld),
    .out_tag        (cap_tag),
    .upstream_empty (pipe_upstream_empty)
  );

  // Program store: host writes are accepted only while no run is active
  always_ff @(posedge clk) begin
    if (prog_we && (state == IDLE)) begin
      prog[prog_addr] <= prog_data;
    end
  end

  // Result capture: the delayed tag says which entry the current res belongs to
  always_ff @(posedge clk) begin
    if (cap_vld) begin
      result[cap_tag] <= res;
    end
  end

  // Registered readback; a same-edge capture to the same index reads the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= result[rd_addr];
    end
  end

  // Run sequencer: issue len words back to back, then wait for the pipe to drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      len_r <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      instr <= '0;
    end else begin
      done <= 1'b0;
      if (cap_vld) begin
        count <= count + CNT_ONE;
      end
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            if (len != '0) begin
              state <= ISSUE;
              len_r <= len;
              pc    <= '0;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          instr <= prog[pc];
          if (last_issue) begin
            state <= DRAIN;
          end else begin
            pc <= pc + PC_ONE;
          end
        end
        DRAIN: begin
          // 8'h00 decodes as ADD 0,0: harmless filler whose results are never captured
          instr <= '0;
          if (cap_vld && pipe_upstream_empty) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_issue_unit.sv
// Closed-loop bench for pipe_issue_unit: a small behavioural 4-stage
// processor closes the instr/res loop, and directed runs check sequencing,
// capture timing, readback, ignored requests and mid-run reset.
module tb_pipe_issue_unit;
  import pipe_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int LAT    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [7:0]        prog_data;
  logic              start;
  logic [ADDR_W:0]   len;
  logic [7:0]        instr;
  logic [7:0]        res;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  int n_assert = 0;
  int n_fail   = 0;

  pipe_issue_unit #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .LAT    (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .len       (len),
    .instr     (instr),
    .res       (res),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural processor: operands are the 3-bit immediates, 4 edges
  // from sampling instr to updating res.
  logic [7:0] p1 = 8'h00, p2 = 8'h00, p3 = 8'h00;
  initial res = 8'h00;

  function automatic logic [7:0] alu(input logic [7:0] w);
    logic [7:0] a, b;
    a = {5'b00000, w[5:3]};
    b = {5'b00000, w[2:0]};
    case (w[7:6])
      ADD:     return a + b;
      SUB:     return a - b;
      LOAD:    return b;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    p1  <= alu(instr);
    p2  <= p1;
    p3  <= p2;
    res <= p3;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  // Returns at S+1ns where S is the edge that samples start
  task automatic start_run(input logic [ADDR_W:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic wait_done(input int lim, output int cyc);
    cyc = -1;
    for (int i = 1; i <= lim; i++) begin
      step();
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] e);
    rd_addr = a;
    step();
    check(tag, 32'(rd_data), 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    int         bc;
    int         ch;
    int         dn;
    logic [7:0] prev;
    logic [7:0] seen [8];
    logic [7:0] exp1 [4];

    exp1 = '{8'h05, 8'h05, 8'hFF, 8'h00};
    for (int i = 0; i < 8; i++) seen[i] = 8'h00;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; len = '0; rd_addr = '0;

    // Reset values
    rst = 1'b1;
    step(); step();
    check("rst_instr", 32'(instr), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    rst = 1'b0;
    step();

    // Scenario 1: four-instruction program
    prog_write(4'd0, 8'h85);
    prog_write(4'd1, 8'h1A);
    prog_write(4'd2, 8'h53);
    prog_write(4'd3, 8'hC0);
    start_run(5'd4);
    check("s1_busy_rise", 32'(busy), 32'h1);
    cyc = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i < 8) seen[i] = instr;
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
    check("s1_instr_k0", 32'(seen[1]), 32'h85);
    check("s1_instr_k1", 32'(seen[2]), 32'h1A);
    check("s1_instr_k2", 32'(seen[3]), 32'h53);
    check("s1_instr_k3", 32'(seen[4]), 32'hC0);
    check("s1_instr_fill", 32'(seen[5]), 32'h00);
    check("s1_done_latency", 32'(cyc), 32'd9);
    check("s1_busy_fall", 32'(busy), 32'h0);
    check("s1_count", 32'(count), 32'd4);
    step();
    check("s1_done_one_cycle", 32'(done), 32'h0);
    check("s1_count_hold", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) rd_check("s1_result", i[3:0], exp1[i]);
    rd_check("s1_readback_addr2", 4'd2, 8'hFF);

    // Scenario 2: sixteen back-to-back ADDs
    for (int i = 0; i < 16; i++) prog_write(i[3:0], {2'b00, i[2:0], 3'b001});
    start_run(5'd16);
    bc = 0;
    ch = 0;
    prev = instr;
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b1) break;
      bc++;
      step();
      if (instr !== prev) ch++;
      prev = instr;
    end
    check("s2_busy_cycles", 32'(bc), 32'd21);
    check("s2_instr_changes", 32'(ch), 32'd17);
    check("s2_done_at_busy_fall", 32'(done), 32'h1);
    check("s2_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) rd_check("s2_result", i[3:0], 8'((i % 8) + 1));

    // Scenario 3: zero-length run
    start_run(5'd0);
    check("s3_done_pulse", 32'(done), 32'h1);
    check("s3_busy_low", 32'(busy), 32'h0);
    check("s3_count_zero", 32'(count), 32'd0);
    step();
    check("s3_done_clear", 32'(done), 32'h0);
    check("s3_busy_still_low", 32'(busy), 32'h0);

    // Scenario 4: start and prog_we during a run are ignored
    prog_write(4'd0, 8'h85);
    prog_write(4'd1, 8'h1A);
    prog_write(4'd2, 8'h53);
    prog_write(4'd3, 8'hC0);
    start_run(5'd4);
    step();
    start = 1'b1; len = 5'd16;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'hFF;
    step();
    start = 1'b0; len = '0; prog_we = 1'b0;
    wait_done(30, cyc);
    check("s4_done_latency", 32'(cyc), 32'd7);
    check("s4_count", 32'(count), 32'd4);
    start_run(5'd1);
    wait_done(20, cyc);
    check("s4_len1_done_latency", 32'(cyc), 32'd6);
    check("s4_len1_count", 32'(count), 32'd1);
    rd_check("s4_prog0_unchanged", 4'd0, 8'h05);
    rd_check("s4_result1", 4'd1, 8'h05);

    // Scenario 5: reset three cycles into a run, then a fresh two-word run
    start_run(5'd4);
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("s5_rst_busy", 32'(busy), 32'h0);
    check("s5_rst_instr", 32'(instr), 32'h00);
    check("s5_rst_done", 32'(done), 32'h0);
    check("s5_rst_count", 32'(count), 32'd0);
    check("s5_rst_rd_data", 32'(rd_data), 32'h00);
    step();
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    check("s5_no_done_after_abort", 32'(dn), 32'd0);
    prog_write(4'd0, 8'h3F);
    // Write and start in the same cycle: the run must see the new word
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 8'h4C;
    start_run(5'd2);
    prog_we = 1'b0;
    check("s5_busy_rise", 32'(busy), 32'h1);
    wait_done(20, cyc);
    check("s5_done_latency", 32'(cyc), 32'd7);
    check("s5_count", 32'(count), 32'd2);
    rd_check("s5_result0", 4'd0, 8'h0E);
    rd_check("s5_result1", 4'd1, 8'hFD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
